// File: rtl/f_fetch_stage_pkg.sv
// Shared constants and types for the F stage: memory window, reset PC,
// NOP encoding, next-PC op codes and the target-buffer state encoding.
package f_fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_TOP   = 32'h0000_6FFC;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    // Next-PC operation selected by the D stage; non-zero means redirect.
    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_op_e;

    // One-entry target buffer: empty, or holding a redirect target.
    typedef enum logic {
        TGT_IDLE = 1'b0,
        TGT_HOLD = 1'b1
    } tgt_state_e;

    // Fetch address is illegal when misaligned or outside the IM window.
    function automatic logic addr_is_bad(input logic [31:0] pc,
                                         input logic [31:0] base,
                                         input logic [31:0] top);
        return (pc[1:0] != 2'b00) || (pc < base) || (pc > top);
    endfunction

endpackage

// File: rtl/f_fetch_stage_if.sv
// Bundle between the F stage, the D-stage next-PC logic and instruction memory.
// The slave modport is the fetch stage; master is its environment.
interface f_fetch_stage_if;
    logic [31:0] NPC;
    logic        redirect;
    logic        stall;
    logic        im_ready;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    logic [31:0] F_PC;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic        D_valid;
    logic        D_excAdEL;

    modport master (
        output NPC, redirect, stall, im_ready, i_inst_rdata,
        input  i_inst_addr, F_PC, D_PC, D_Instr, D_valid, D_excAdEL
    );

    modport slave (
        input  NPC, redirect, stall, im_ready, i_inst_rdata,
        output i_inst_addr, F_PC, D_PC, D_Instr, D_valid, D_excAdEL
    );
endinterface

// File: rtl/f_tgt_buf.sv
// One-entry branch-target buffer. Captures a redirect target seen during an
// instruction-memory wait state so it survives until the delay slot is fetched.
module f_tgt_buf
    import f_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        im_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] npc_i,
    output logic        tgt_valid_o,
    output logic [31:0] tgt_buf_o
);

    tgt_state_e  state_q;
    logic        tgt_valid_q;
    logic [31:0] tgt_buf_q;

    // Capture on redirect during a wait, consume on the next advance, hold on stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= TGT_IDLE;
            tgt_valid_q <= 1'b0;
            tgt_buf_q   <= '0;
        end else if (!stall_i) begin
            case (state_q)
                TGT_IDLE: begin
                    if (!im_ready_i && redirect_i) begin
                        tgt_buf_q   <= npc_i;
                        state_q     <= TGT_HOLD;
                        tgt_valid_q <= 1'b1;
                    end
                end
                TGT_HOLD: begin
                    if (im_ready_i) begin
                        state_q     <= TGT_IDLE;
                        tgt_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= TGT_IDLE;
                    tgt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign tgt_valid_o = tgt_valid_q;
    assign tgt_buf_o   = tgt_buf_q;

endmodule

// File: rtl/f_fetch_stage.sv
// F-stage PC register and F/D pipeline register. A redirect arriving while
// instruction memory is waiting is parked in f_tgt_buf and applied once the
// delay slot has been fetched.
module f_fetch_stage
    import f_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
    parameter logic [31:0] IM_TOP   = DEF_IM_TOP
) (
    input  logic           clk,
    input  logic           reset,
    f_fetch_stage_if.slave bus
);

    logic [31:0] f_pc_q,    f_pc_d;
    logic [31:0] d_pc_q,    d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic        d_valid_q, d_valid_d;
    logic        d_exc_q,   d_exc_d;

    logic        advance;
    logic        fetch_bad;
    logic        tgt_valid;
    logic [31:0] tgt_buf;

    assign advance   = !bus.stall && bus.im_ready;
    assign fetch_bad = addr_is_bad(f_pc_q, IM_BASE, IM_TOP);

    f_tgt_buf u_tgt_buf (
        .clk         (clk),
        .reset       (reset),
        .stall_i     (bus.stall),
        .im_ready_i  (bus.im_ready),
        .redirect_i  (bus.redirect),
        .npc_i       (bus.NPC),
        .tgt_valid_o (tgt_valid),
        .tgt_buf_o   (tgt_buf)
    );

    // Next state: advance fetches, a wait inserts a bubble, a stall holds everything.
    always_comb begin
        f_pc_d    = f_pc_q;
        d_pc_d    = d_pc_q;
        d_instr_d = d_instr_q;
        d_valid_d = d_valid_q;
        d_exc_d   = d_exc_q;
        if (advance) begin
            // A parked target wins over NPC, which is stale while D holds bubbles.
            f_pc_d    = tgt_valid ? tgt_buf : bus.NPC;
            d_pc_d    = f_pc_q;
            d_valid_d = 1'b1;
            d_exc_d   = fetch_bad;
            d_instr_d = fetch_bad ? NOP_INSTR : bus.i_inst_rdata;
        end else if (!bus.stall) begin
            d_pc_d    = '0;
            d_instr_d = NOP_INSTR;
            d_valid_d = 1'b0;
            d_exc_d   = 1'b0;
        end
    end

    // PC and F/D registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            f_pc_q    <= RESET_PC;
            d_pc_q    <= '0;
            d_instr_q <= NOP_INSTR;
            d_valid_q <= 1'b0;
            d_exc_q   <= 1'b0;
        end else begin
            f_pc_q    <= f_pc_d;
            d_pc_q    <= d_pc_d;
            d_instr_q <= d_instr_d;
            d_valid_q <= d_valid_d;
            d_exc_q   <= d_exc_d;
        end
    end

    assign bus.i_inst_addr = f_pc_q;
    assign bus.F_PC        = f_pc_q;
    assign bus.D_PC        = d_pc_q;
    assign bus.D_Instr     = d_instr_q;
    assign bus.D_valid     = d_valid_q;
    assign bus.D_excAdEL   = d_exc_q;

endmodule

// File: tb/tb_f_fetch_stage.sv
// Bench for f_fetch_stage: directed vectors with literal expectations plus a
// cycle-level reference model checked after every rising edge.
module tb_f_fetch_stage;

    logic clk;
    logic reset;

    f_fetch_stage_if bus ();

    f_fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: a pattern derived from the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign bus.i_inst_rdata = imem(bus.i_inst_addr);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_dpc, m_dinst, m_tgt;
    logic        m_dv, m_dexc, m_tv;
    bit          m_known = 0;
    int          cyc = 0;

    initial begin
        forever begin
            logic        s_rst, s_stall, s_rdy, s_rdr, bad;
            logic [31:0] s_npc;
            @(posedge clk);
            s_rst = reset; s_stall = bus.stall; s_rdy = bus.im_ready;
            s_rdr = bus.redirect; s_npc = bus.NPC;
            if (!s_rst) begin
                m_pc = 32'h3000; m_dpc = 0; m_dinst = 0; m_dv = 0; m_dexc = 0;
                m_tv = 0; m_tgt = 0; m_known = 1;
            end else if (m_known && !s_stall) begin
                if (s_rdy) begin
                    bad     = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h6FFC);
                    m_dpc   = m_pc;
                    m_dv    = 1;
                    m_dexc  = bad;
                    m_dinst = bad ? 32'h0 : imem(m_pc);
                    m_pc    = m_tv ? m_tgt : s_npc;
                    m_tv    = 0;
                end else begin
                    m_dpc = 0; m_dinst = 0; m_dv = 0; m_dexc = 0;
                    if (s_rdr && !m_tv) begin
                        m_tgt = s_npc;
                        m_tv  = 1;
                    end
                end
            end
            #1;
            cyc++;
            if (m_known) begin
                $display("cyc %0d rst=%b stall=%b rdy=%b rdr=%b npc=%08h | F_PC=%08h D_PC=%08h D_Instr=%08h v=%b exc=%b",
                         cyc, s_rst, s_stall, s_rdy, s_rdr, s_npc, bus.F_PC, bus.D_PC,
                         bus.D_Instr, bus.D_valid, bus.D_excAdEL);
                chk("model F_PC",      bus.F_PC,        m_pc);
                chk("model i_addr",    bus.i_inst_addr, m_pc);
                chk("model D_PC",      bus.D_PC,        m_dpc);
                chk("model D_Instr",   bus.D_Instr,     m_dinst);
                chk("model D_valid",   {31'b0, bus.D_valid},   {31'b0, m_dv});
                chk("model D_excAdEL", {31'b0, bus.D_excAdEL}, {31'b0, m_dexc});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rst, input logic stl, input logic rdy,
                         input logic rdr, input logic [31:0] npc);
        reset        = rst;
        bus.stall    = stl;
        bus.im_ready = rdy;
        bus.redirect = rdr;
        bus.NPC      = npc;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_d(input string name, input logic [31:0] pc,
                         input logic [31:0] ins, input logic v, input logic e);
        chk({name, " D_PC"},      bus.D_PC, pc);
        chk({name, " D_Instr"},   bus.D_Instr, ins);
        chk({name, " D_valid"},   {31'b0, bus.D_valid}, {31'b0, v});
        chk({name, " D_excAdEL"}, {31'b0, bus.D_excAdEL}, {31'b0, e});
    endtask

    initial begin
        logic [31:0] rnpc;
        drive(0, 0, 1, 0, 32'h0);
        tick(); tick();
        chk("rst F_PC", bus.F_PC, 32'h3000);
        chk("rst tgt_valid", {31'b0, dut.tgt_valid}, 32'h0);
        chk_d("rst", 32'h0, 32'h0, 0, 0);

        // Sequential fetch
        drive(1, 0, 1, 0, 32'h3004); tick();
        chk("seq1 F_PC", bus.F_PC, 32'h3004);
        chk_d("seq1", 32'h3000, 32'h3000CFFF, 1, 0);
        drive(1, 0, 1, 0, 32'h3008); tick();
        chk("seq2 F_PC", bus.F_PC, 32'h3008);
        chk_d("seq2", 32'h3004, 32'h3004CFFB, 1, 0);

        // Stall holds for two cycles
        drive(1, 1, 1, 0, 32'h300C); tick(); tick();
        chk("stall F_PC", bus.F_PC, 32'h3008);
        chk_d("stall", 32'h3004, 32'h3004CFFB, 1, 0);
        drive(1, 0, 1, 0, 32'h300C); tick();
        chk("unstall F_PC", bus.F_PC, 32'h300C);
        chk_d("unstall", 32'h3008, 32'h3008CFF7, 1, 0);

        // Branch in D (0x3008) with two wait cycles
        drive(1, 0, 0, 1, 32'h3100); tick();
        chk("wait1 F_PC", bus.F_PC, 32'h300C);
        chk("wait1 tgt_valid", {31'b0, dut.tgt_valid}, 32'h1);
        chk_d("wait1", 32'h0, 32'h0, 0, 0);
        drive(1, 0, 0, 0, 32'h3010); tick();
        chk("wait2 F_PC", bus.F_PC, 32'h300C);
        chk("wait2 tgt_valid", {31'b0, dut.tgt_valid}, 32'h1);
        drive(1, 0, 1, 0, 32'h3010); tick();
        chk("release F_PC", bus.F_PC, 32'h3100);
        chk("release tgt_valid", {31'b0, dut.tgt_valid}, 32'h0);
        chk_d("delay slot", 32'h300C, 32'h300CCFF3, 1, 0);

        // Redirect without wait
        drive(1, 0, 1, 1, 32'h3400); tick();
        chk("redir F_PC", bus.F_PC, 32'h3400);
        chk("redir tgt_valid", {31'b0, dut.tgt_valid}, 32'h0);

        // Address faults and window edges
        drive(1, 0, 1, 1, 32'h3002); tick();
        chk("mis F_PC", bus.F_PC, 32'h3002);
        drive(1, 0, 1, 1, 32'h7000); tick();
        chk_d("misaligned", 32'h3002, 32'h0, 1, 1);
        drive(1, 0, 1, 1, 32'h6FFC); tick();
        chk_d("above top", 32'h7000, 32'h0, 1, 1);
        drive(1, 0, 1, 1, 32'h2FFC); tick();
        chk_d("at top", 32'h6FFC, 32'h6FFC9003, 1, 0);
        drive(1, 0, 1, 1, 32'hFFFFFFFC); tick();
        chk_d("below base", 32'h2FFC, 32'h0, 1, 1);
        drive(1, 0, 1, 1, 32'h3000); tick();
        chk_d("max pc", 32'hFFFFFFFC, 32'h0, 1, 1);
        drive(1, 0, 1, 0, 32'h3004); tick();
        chk_d("at base", 32'h3000, 32'h3000CFFF, 1, 0);

        // Reset while holding a target
        drive(1, 0, 0, 1, 32'h3200); tick();
        chk("hold tgt_valid", {31'b0, dut.tgt_valid}, 32'h1);
        drive(0, 0, 0, 1, 32'h3300); tick();
        chk("hold rst F_PC", bus.F_PC, 32'h3000);
        chk("hold rst tgt_valid", {31'b0, dut.tgt_valid}, 32'h0);
        chk("hold rst D_valid", {31'b0, bus.D_valid}, 32'h0);
        drive(1, 0, 1, 0, 32'h3004); tick();
        chk("post rst F_PC", bus.F_PC, 32'h3004);

        // Stall while holding a target keeps everything
        drive(1, 0, 0, 1, 32'h3500); tick();
        drive(1, 1, 0, 1, 32'h3600); tick();
        drive(1, 1, 1, 1, 32'h3700); tick();
        chk("hold stall F_PC", bus.F_PC, 32'h3004);
        chk("hold stall tgt_valid", {31'b0, dut.tgt_valid}, 32'h1);
        chk("hold stall D_valid", {31'b0, bus.D_valid}, 32'h0);
        drive(1, 0, 1, 1, 32'h3800); tick();
        chk("hold consume F_PC", bus.F_PC, 32'h3500);
        chk("hold consume tgt_valid", {31'b0, dut.tgt_valid}, 32'h0);
        chk_d("hold consume", 32'h3004, 32'h3004CFFB, 1, 0);

        // Mixed traffic checked by the model
        for (int i = 0; i < 40; i++) begin
            logic rdr;
            rdr  = ($urandom % 4) == 0;
            rnpc = rdr ? ($urandom_range(32'h2F00, 32'h7100) & ~32'h3) : m_pc + 32'h4;
            if (($urandom % 8) == 0) rnpc = rnpc | 32'h2;
            drive(($urandom % 25) != 0, ($urandom % 5) == 0, ($urandom % 3) != 0, rdr, rnpc);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
